alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial sequencer that performs WIDTH-bit AND/OR/XOR/ADD/SUB operations on the team's 1-bit ALU slice (`alu_1bit`). It sits between a requester and one external `alu_1bit` instance. It accepts a word-level command through a start/busy/done handshake. It then drives operand bits LSB-first into the slice, one bit per clock, feeding the slice's carry-out back as the next bit's carry-in. When all bits are done it presents the assembled result and flags.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: command request; sampled only in IDLE.
- `op_in` input 3: opcode. 000 AND, 010 OR, 011 XOR, 100 ADD/SUB. All other codes are illegal.
- `bneg_in` input 1: with op 100, 1 selects SUB (a − b); ignored for the other opcodes.
- `a_in`, `b_in` input WIDTH: operands, captured on the accepting edge.
- `busy` output 1: high while bits are being processed.
- `done` output 1: one-cycle pulse marking the result as valid.
- `result_out` output WIDTH: result; holds its value until the next accepted start.
- `carry_out` output 1: final slice carry for ADD/SUB (for SUB, 1 = no borrow); 0 for logic ops.
- `overflow_out` output 1: signed overflow for ADD/SUB; 0 for logic ops.
- `zero_out` output 1: result_out == 0.
- `err_out` output 1: the last accepted command had an illegal opcode.
- `alu_a`, `alu_b`, `alu_cin`, `alu_bnegate` output 1: drive the slice inputs.
- `alu_op` output 3: drives the slice opcode.
- `alu_result`, `alu_cout` input 1: slice outputs; combinational in the same cycle.

## Operation
- FSM states: IDLE, RUN, DONE. Reset places the FSM in IDLE.
- IDLE with start=1 and a legal op:
  - Capture a_in→a_sh, b_in→b_sh, op_in→op_q.
  - Set bneg_q = bneg_in & (op_in==100).
  - Set carry_q = bneg_q, so SUB gets cin=1 on bit 0 and all other ops get 0.
  - Clear cnt and err_out, then go to RUN.
- IDLE with start=1 and an illegal op:
  - Set err_out=1 and result_out=0; clear all flags.
  - Go directly to DONE without entering RUN.
- In RUN, the slice is driven as follows: alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry_q, alu_bnegate=bneg_q, alu_op=op_q.
- Each RUN edge:
  - Shift a_sh and b_sh right by one.
  - Shift alu_result into the result register at bit WIDTH-1 (right shift).
  - Set carry_q = alu_cout for op 100; otherwise 0.
  - Increment cnt.
- On the RUN edge where cnt==WIDTH-1:
  - Load result_out from the shifted register.
  - For op 100: carry_out=alu_cout and overflow_out=carry_q^alu_cout, where carry_q is the carry into the MSB.
  - zero_out reflects the final result.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- A start while in RUN or DONE is ignored and is not queued.
- Outside RUN, alu_a/alu_b/alu_cin/alu_bnegate are driven to 0 and alu_op holds op_q.

## Timing
- Reset values: busy=0, done=0, result_out=0, carry_out=0, overflow_out=0, zero_out=0, err_out=0, all alu_* outputs=0, cnt=0, state=IDLE.
- Take the accepting edge as E0:
  - busy is high from after E0 until edge E_WIDTH.
  - Bit i is presented to the slice in the cycle between E_i and E_(i+1).
  - done and the final outputs are valid in the cycle after E_WIDTH, i.e. latency WIDTH+1 cycles from start to done.
- Illegal op: done is high in the cycle immediately after E0 and busy never rises.
- Back-to-back commands: start may be asserted in the cycle after done and is accepted.
- Reset asserted mid-RUN:
  - All state and outputs clear immediately, without waiting for a clock.
  - The partial result is discarded and no done pulse is produced.
- cnt width is clog2(WIDTH); cnt does not wrap, because the FSM exits RUN at WIDTH-1.

## Test plan
- ADD, WIDTH=8, a=0x5A, b=0x3C → done 9 cycles after start; result 0x96, carry 0, overflow 1, zero 0.
- ADD, a=0xFF, b=0x01 → result 0x00, carry 1, overflow 0, zero 1. SUB, a=0x00, b=0x01 → result 0xFF, carry 0 (borrow), overflow 0.
- SUB, a=0x10, b=0x01 → result 0x0F, carry 1. SUB, a=0x80, b=0x01 → result 0x7F, overflow 1.
- AND 0xF0&0x3C → 0x30. OR 0xF0|0x0C → 0xFC. XOR 0xFF^0xFF → 0x00 with zero 1. All three have carry 0 and overflow 0, and alu_bnegate stays 0 even with bneg_in=1.
- op_in=001 → done in the cycle after start, err_out=1, result 0, busy never high. A following legal ADD clears err_out.
- start pulsed again during RUN → ignored; the first result is unchanged. rst_n pulled low at bit 4 of 8 → all outputs 0 asynchronously and no done pulse; a new start after release completes normally.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial word ALU sequencer: drives an external 1-bit ALU slice LSB-first,
// rippling the slice carry between bits, and assembles the word result and flags.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_in,
  input  logic             bneg_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             zero_out,
  output logic             err_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_bnegate,
  output logic [2:0]       alu_op,
  input  logic             alu_result,
  input  logic             alu_cout
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, result_q;
  logic [2:0]       op_q;
  logic             bneg_q, carry_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_out_q, ovf_q, zero_q, err_q;

  logic             op_legal, last_bit, is_arith, start_sub;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    op_legal = 1'b0;
    case (op_in)
      3'b000, 3'b010, 3'b011, 3'b100: op_legal = 1'b1;
      default:                        op_legal = 1'b0;
    endcase
    start_sub = bneg_in & (op_in == 3'b100);
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
    is_arith  = (op_q == 3'b100);
    res_next  = {alu_result, res_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b0;
    done        = 1'b0;
    alu_a       = 1'b0;
    alu_b       = 1'b0;
    alu_cin     = 1'b0;
    alu_bnegate = 1'b0;
    alu_op      = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = op_legal ? StRun : StDone;
      end
      StRun: begin
        busy        = 1'b1;
        alu_a       = a_sh_q[0];
        alu_b       = b_sh_q[0];
        alu_cin     = carry_q;
        alu_bnegate = bneg_q;
        if (last_bit) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      result_q    <= '0;
      op_q        <= '0;
      bneg_q      <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (state_q == StIdle && start) begin
      if (op_legal) begin
        a_sh_q  <= a_in;
        b_sh_q  <= b_in;
        op_q    <= op_in;
        bneg_q  <= start_sub;
        carry_q <= start_sub;  // SUB needs cin=1 on bit 0 for two's complement
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        err_q       <= 1'b1;
        result_q    <= '0;
        carry_out_q <= 1'b0;
        ovf_q       <= 1'b0;
        zero_q      <= 1'b0;
      end
    end else if (state_q == StRun) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= res_next;
      carry_q  <= is_arith & alu_cout;
      cnt_q    <= last_bit ? '0 : cnt_q + CntW'(1);
      if (last_bit) begin
        result_q    <= res_next;
        carry_out_q <= is_arith & alu_cout;
        // carry_q here is the carry into the MSB
        ovf_q       <= is_arith & (carry_q ^ alu_cout);
        zero_q      <= (res_next == '0);
      end
    end
  end

  assign result_out   = result_q;
  assign carry_out    = carry_out_q;
  assign overflow_out = ovf_q;
  assign zero_out     = zero_q;
  assign err_out      = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: behavioural slice, word-level reference
// model, randomized and directed commands.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c, v, z, e;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0, rst_n;
  logic         start, bneg_in;
  logic [2:0]   op_in;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, carry_out, overflow_out, zero_out, err_out;
  logic [W-1:0] result_out;
  logic         alu_a, alu_b, alu_cin, alu_bnegate, alu_result, alu_cout;
  logic [2:0]   alu_op;

  int   checks = 0, passed = 0, cyc = 0;
  exp_t sb[$];
  logic [2:0] cur_op = 3'b000;
  logic       cur_bneg = 1'b0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in), .bneg_in(bneg_in),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result_out(result_out),
    .carry_out(carry_out), .overflow_out(overflow_out), .zero_out(zero_out),
    .err_out(err_out), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_bnegate(alu_bnegate), .alu_op(alu_op), .alu_result(alu_result),
    .alu_cout(alu_cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 1-bit ALU slice
  logic bb;
  always_comb begin
    bb       = alu_b ^ alu_bnegate;
    alu_cout = (alu_a & bb) | (alu_a & alu_cin) | (bb & alu_cin);
    case (alu_op)
      3'b000:  alu_result = alu_a & bb;
      3'b010:  alu_result = alu_a | bb;
      3'b011:  alu_result = alu_a ^ bb;
      3'b100:  alu_result = alu_a ^ bb ^ alu_cin;
      default: alu_result = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, got, exp);
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic bn,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    logic [W:0]   s;
    logic [W-1:0] bv;
    x.res = '0; x.c = 1'b0; x.v = 1'b0; x.e = 1'b0; x.cyc = 0;
    case (op)
      3'b000: x.res = a & b;
      3'b010: x.res = a | b;
      3'b011: x.res = a ^ b;
      3'b100: begin
        bv    = bn ? ~b : b;
        s     = {1'b0, a} + {1'b0, bv} + {{W{1'b0}}, bn};
        x.res = s[W-1:0];
        x.c   = s[W];
        x.v   = (a[W-1] == bv[W-1]) && (x.res[W-1] != a[W-1]);
      end
      default: x.e = 1'b1;
    endcase
    x.z = !x.e && (x.res == '0);
    return x;
  endfunction

  // Monitor: pops the scoreboard whenever done is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && busy) chk("alu_ctl", {alu_bnegate, alu_op}, {cur_bneg, cur_op});
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_done: done seen with nothing outstanding, required no done");
      end else begin
        e = sb.pop_front();
        chk("result_flags", {result_out, carry_out, overflow_out, zero_out, err_out},
            {e.res, e.c, e.v, e.z, e.e});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic bn, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    exp_t x;
    @(negedge clk);
    start = 1'b1; op_in = op; bneg_in = bn; a_in = a; b_in = b;
    x = model(op, bn, a, b);
    x.cyc = x.e ? cyc + 1 : cyc + 1 + W;
    if (!x.e) begin
      cur_op   = op;
      cur_bneg = bn & (op == 3'b100);
    end
    sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < W + 4 && !done; i++) @(negedge clk);
    if (!done) begin
      checks++;
      $display("FAIL done_timeout: done not seen, required within %0d cycles", W + 4);
      sb.delete();
    end
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic bn, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    send(op, bn, a, b);
    wait_done();
    if (model(op, bn, a, b).e) chk("illegal_busy", busy, 1'b0);
  endtask

  task automatic no_done(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    logic [2:0] ops[10];
    ops = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b100, 3'b100, 3'b001, 3'b101, 3'b110, 3'b111};
    rst_n = 1'b0; start = 1'b0; op_in = '0; bneg_in = 1'b0; a_in = '0; b_in = '0;
    #1;
    chk("reset_outputs", {busy, done, result_out, carry_out, overflow_out, zero_out, err_out,
                          alu_a, alu_b, alu_cin, alu_bnegate, alu_op}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_cmd(3'b100, 1'b0, 8'h5A, 8'h3C);
    run_cmd(3'b100, 1'b0, 8'hFF, 8'h01);
    run_cmd(3'b100, 1'b1, 8'h00, 8'h01);
    run_cmd(3'b100, 1'b1, 8'h10, 8'h01);
    run_cmd(3'b100, 1'b1, 8'h80, 8'h01);
    run_cmd(3'b000, 1'b1, 8'hF0, 8'h3C);
    run_cmd(3'b010, 1'b1, 8'hF0, 8'h0C);
    run_cmd(3'b011, 1'b1, 8'hFF, 8'hFF);
    run_cmd(3'b001, 1'b0, 8'h12, 8'h34);
    run_cmd(3'b100, 1'b0, 8'h01, 8'h02);

    // start during RUN must be ignored
    send(3'b100, 1'b0, 8'h5A, 8'h3C);
    repeat (3) @(negedge clk);
    start = 1'b1; op_in = 3'b011; a_in = 8'hFF; b_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    no_done("ignored_start_no_done", 12);

    // asynchronous reset while bit 4 is on the slice
    send(3'b100, 1'b0, 8'h77, 8'h11);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, done, result_out, carry_out, overflow_out, zero_out,
                                err_out, alu_a, alu_b, alu_cin, alu_bnegate, alu_op}, '0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_done("reset_no_done", 12);
    run_cmd(3'b100, 1'b1, 8'h33, 8'h44);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_cmd(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
